microblaze_subsys: RTL and testbench

//  UART-controlled dual-channel (I/Q) 10-bit DAC driver; replaces the soft-CPU system behind the board top.

---
 rtl/mbs_pkg.sv | 37 +++
 rtl/mbs_uart.sv | 131 +++++++++++++
 rtl/microblaze_subsys.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_microblaze_subsys.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mbs_pkg.sv
// Shared constants and state types for the UART-controlled I/Q DAC driver.
// Covers register map, protocol bytes, CTRL bit positions and FSM encodings.
package mbs_pkg;

  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_I    = 4'h1;
  localparam logic [3:0] ADDR_Q    = 4'h2;
  localparam logic [3:0] ADDR_DIV  = 4'h3;
  localparam logic [3:0] ADDR_STEP = 4'h4;
  localparam logic [3:0] ADDR_ID   = 4'hF;

  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  localparam int CTRL_PWRDN  = 0;
  localparam int CTRL_OPENI  = 1;
  localparam int CTRL_OPENQ  = 2;
  localparam int CTRL_FORMAT = 3;
  localparam int CTRL_PINMD  = 4;
  localparam int CTRL_CLKMD  = 5;
  localparam int CTRL_RUN    = 6;
  localparam int CTRL_RAMP   = 7;

  localparam logic [15:0] ID_VALUE   = 16'hDAC1;
  localparam logic [15:0] CTRL_RESET = 16'h0001;
  localparam logic [15:0] DIV_RESET  = 16'd3;

  typedef enum logic [1:0] {P_IDLE, P_DHI, P_DLO, P_EXEC} parse_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [0:0] {T_IDLE, T_SEND} tx_state_t;

  // Format=1 flips the MSB: offset-binary to two's complement.
  function automatic logic [9:0] dac_code(input logic [9:0] s, input logic fmt);
    return fmt ? (s ^ 10'h200) : s;
  endfunction

endpackage

// File: rtl/mbs_uart.sv
// 8N1 UART: rx with 2-FF sync and mid-bit sampling, tx with single-byte valid/ready accept.
// rx_vld/rx_ferr pulse one cycle after the stop-bit sample; tx_rdy is high only while idle.
module mbs_uart
  import mbs_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       rx_ferr,
  input  logic       tx_vld,
  input  logic [7:0] tx_dat,
  output logic       tx_rdy
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);

  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic          rx_s;
  rx_state_t     rx_st, rx_nxt;
  logic [CW-1:0] rx_tmr;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s   = rx_sync[1];
  assign rx_dat = rx_sh;

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_prev && !rx_s) rx_nxt = R_START;
      R_START: if (rx_tmr == HALF) rx_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tmr == FULL && rx_bit == 3'd7) rx_nxt = R_STOP;
      R_STOP:  if (rx_tmr == FULL) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_st   <= R_IDLE;
      rx_tmr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
      rx_st   <= rx_nxt;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_st)
        R_IDLE: begin
          rx_tmr <= '0;
          rx_bit <= '0;
        end
        R_START: rx_tmr <= (rx_tmr == HALF) ? '0 : rx_tmr + 1'b1;
        R_DATA: begin
          if (rx_tmr == FULL) begin
            rx_tmr <= '0;
            rx_bit <= rx_bit + 1'b1;
            rx_sh  <= {rx_s, rx_sh[7:1]};
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_tmr == FULL) begin
            rx_tmr  <= '0;
            rx_vld  <= rx_s;
            rx_ferr <= !rx_s;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        default: rx_tmr <= '0;
      endcase
    end
  end

  tx_state_t     tx_st, tx_nxt;
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_tmr;
  logic [3:0]    tx_cnt;

  // The shifter idles at all-ones so the line rests high.
  assign tx     = tx_sh[0];
  assign tx_rdy = (tx_st == T_IDLE);

  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      T_IDLE:  if (tx_vld) tx_nxt = T_SEND;
      T_SEND:  if (tx_tmr == FULL && tx_cnt == 4'd9) tx_nxt = T_IDLE;
      default: tx_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= T_IDLE;
      tx_sh  <= '1;
      tx_tmr <= '0;
      tx_cnt <= '0;
    end else begin
      tx_st <= tx_nxt;
      if (tx_st == T_IDLE) begin
        tx_tmr <= '0;
        tx_cnt <= '0;
        if (tx_vld) tx_sh <= {1'b1, tx_dat, 1'b0};
      end else if (tx_tmr == FULL) begin
        tx_tmr <= '0;
        tx_cnt <= tx_cnt + 1'b1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
      end else begin
        tx_tmr <= tx_tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/microblaze_subsys.sv
// UART register interface driving a dual-channel I/Q 10-bit DAC; ramp generator under `DAC_RAMP_GEN_EN.
// Responses sit in a 2-byte holding buffer ahead of TX; overflow bytes are dropped, RX is never stalled.
module microblaze_subsys
  import mbs_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int TMO_BITS = 256
) (
  input  logic       fpga_0_clk_1_sys_clk_pin,
  input  logic       fpga_0_rst_1_sys_rst_pin,
  input  logic       fpga_0_RS232_RX_pin,
  output logic       fpga_0_RS232_TX_pin,
  output logic [0:9] plb_dac_0_S_Data_pin,
  output logic       plb_dac_0_S_DCLKIO_pin,
  output logic       plb_dac_0_S_Clkout_pin,
  output logic       plb_dac_0_S_PinMD_pin,
  output logic       plb_dac_0_S_ClkMD_pin,
  output logic       plb_dac_0_S_Format_pin,
  output logic       plb_dac_0_S_PWRDN_pin,
  output logic       plb_dac_0_S_OpEnI_pin,
  output logic       plb_dac_0_S_OpEnQ_pin
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int TMO_CYC = TMO_BITS * BIT_CYC;
`ifdef DAC_RAMP_GEN_EN
  localparam int CTRL_W = 8;
`else
  localparam int CTRL_W = 7;
`endif

  logic clk, rst;
  assign clk = fpga_0_clk_1_sys_clk_pin;
  assign rst = fpga_0_rst_1_sys_rst_pin;

  logic       rx_vld, rx_ferr, tx_vld, tx_rdy;
  logic [7:0] rx_dat, tx_dat;

  mbs_uart #(.BIT_CYC(BIT_CYC)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .rx      (fpga_0_RS232_RX_pin),
    .tx      (fpga_0_RS232_TX_pin),
    .rx_vld  (rx_vld),
    .rx_dat  (rx_dat),
    .rx_ferr (rx_ferr),
    .tx_vld  (tx_vld),
    .tx_dat  (tx_dat),
    .tx_rdy  (tx_rdy)
  );

  logic [CTRL_W-1:0] ctrl_q;
  logic [9:0]        i_q, q_q;
  logic [15:0]       div_q;
`ifdef DAC_RAMP_GEN_EN
  logic [9:0]        step_q;
`endif

  parse_state_t p_st, p_nxt;
  logic [3:0]   addr_q;
  logic [7:0]   dhi_q, dlo_q;
  logic [31:0]  tmo_cnt;
  logic         tmo;
  logic [15:0]  wr_dat;
  logic         wr_en, wr_ok, rd_ok;
  logic [15:0]  rd_val;
  logic [1:0]   resp_n;
  logic [7:0]   resp_b0, resp_b1;

  assign wr_dat = {dhi_q, dlo_q};
  assign tmo    = (tmo_cnt == 32'(TMO_CYC - 1));

  // Reads are answered in IDLE, so the mux decodes the command byte as it arrives.
  always_comb begin
    rd_ok  = 1'b1;
    rd_val = '0;
    case (rx_dat[3:0])
      ADDR_CTRL: rd_val = 16'(ctrl_q);
      ADDR_I:    rd_val = 16'(i_q);
      ADDR_Q:    rd_val = 16'(q_q);
      ADDR_DIV:  rd_val = div_q;
`ifdef DAC_RAMP_GEN_EN
      ADDR_STEP: rd_val = 16'(step_q);
`endif
      ADDR_ID:   rd_val = ID_VALUE;
      default:   rd_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (addr_q)
      ADDR_CTRL, ADDR_I, ADDR_Q, ADDR_DIV: wr_ok = 1'b1;
`ifdef DAC_RAMP_GEN_EN
      ADDR_STEP: wr_ok = 1'b1;
`endif
      default: wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    p_nxt   = p_st;
    resp_n  = 2'd0;
    resp_b0 = BYTE_NAK;
    resp_b1 = 8'h00;
    wr_en   = 1'b0;
    if (rx_ferr) begin
      p_nxt = P_IDLE;
    end else begin
      case (p_st)
        P_IDLE: begin
          if (rx_vld) begin
            if (rx_dat[6:4] != 3'b000) begin
              resp_n = 2'd1;
            end else if (rx_dat[7]) begin
              if (rd_ok) begin
                resp_n  = 2'd2;
                resp_b0 = rd_val[15:8];
                resp_b1 = rd_val[7:0];
              end else begin
                resp_n = 2'd1;
              end
            end else begin
              p_nxt = P_DHI;
            end
          end
        end
        P_DHI: begin
          if (rx_vld)   p_nxt = P_DLO;
          else if (tmo) p_nxt = P_IDLE;
        end
        P_DLO: begin
          if (rx_vld)   p_nxt = P_EXEC;
          else if (tmo) p_nxt = P_IDLE;
        end
        P_EXEC: begin
          p_nxt  = P_IDLE;
          resp_n = 2'd1;
          if (wr_ok) begin
            wr_en   = 1'b1;
            resp_b0 = BYTE_ACK;
          end
        end
        default: p_nxt = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_st    <= P_IDLE;
      addr_q  <= '0;
      dhi_q   <= '0;
      dlo_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      p_st <= p_nxt;
      if (rx_vld && p_st == P_IDLE) addr_q <= rx_dat[3:0];
      if (rx_vld && p_st == P_DHI)  dhi_q  <= rx_dat;
      if (rx_vld && p_st == P_DLO)  dlo_q  <= rx_dat;
      tmo_cnt <= (rx_vld || p_st == P_IDLE) ? '0 : tmo_cnt + 1'b1;
    end
  end

  logic [7:0] rb0_q, rb1_q, rb0_n, rb1_n;
  logic [1:0] rb_cnt, rb_cnt_n;

  assign tx_vld = (rb_cnt != 2'd0);
  assign tx_dat = rb0_q;

  // Pop first so a byte leaving for TX frees a slot for a same-cycle response.
  always_comb begin
    rb0_n    = rb0_q;
    rb1_n    = rb1_q;
    rb_cnt_n = rb_cnt;
    if (tx_vld && tx_rdy) begin
      rb0_n    = rb1_q;
      rb_cnt_n = rb_cnt - 2'd1;
    end
    if (resp_n != 2'd0 && rb_cnt_n < 2'd2) begin
      if (rb_cnt_n == 2'd0) rb0_n = resp_b0;
      else                  rb1_n = resp_b0;
      rb_cnt_n = rb_cnt_n + 2'd1;
    end
    if (resp_n == 2'd2 && rb_cnt_n < 2'd2) begin
      rb1_n    = resp_b1;
      rb_cnt_n = rb_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb0_q  <= '0;
      rb1_q  <= '0;
      rb_cnt <= '0;
    end else begin
      rb0_q  <= rb0_n;
      rb1_q  <= rb1_n;
      rb_cnt <= rb_cnt_n;
    end
  end

  logic [15:0] div_cnt;
  logic        dclk_q, tick;
  logic [9:0]  data_q;

  assign tick = ctrl_q[CTRL_RUN] && (div_cnt >= div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_RESET[CTRL_W-1:0];
      i_q    <= '0;
      q_q    <= '0;
      div_q  <= DIV_RESET;
`ifdef DAC_RAMP_GEN_EN
      step_q <= '0;
`endif
    end else begin
`ifdef DAC_RAMP_GEN_EN
      if (tick && !dclk_q && ctrl_q[CTRL_RAMP]) begin
        i_q <= i_q + step_q;
        q_q <= q_q - step_q;
      end
`endif
      // Host writes override a same-cycle ramp update.
      if (wr_en) begin
        case (addr_q)
          ADDR_CTRL: ctrl_q <= wr_dat[CTRL_W-1:0];
          ADDR_I:    i_q    <= wr_dat[9:0];
          ADDR_Q:    q_q    <= wr_dat[9:0];
          ADDR_DIV:  div_q  <= wr_dat;
`ifdef DAC_RAMP_GEN_EN
          ADDR_STEP: step_q <= wr_dat[9:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dclk_q  <= 1'b0;
      data_q  <= '0;
    end else if (!ctrl_q[CTRL_RUN]) begin
      div_cnt <= '0;
      dclk_q  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      dclk_q  <= !dclk_q;
      data_q  <= dclk_q ? dac_code(i_q, ctrl_q[CTRL_FORMAT])
                        : dac_code(q_q, ctrl_q[CTRL_FORMAT]);
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic pwrdn_q, openi_q, openq_q, format_q, pinmd_q, clkmd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwrdn_q  <= 1'b1;
      openi_q  <= 1'b0;
      openq_q  <= 1'b0;
      format_q <= 1'b0;
      pinmd_q  <= 1'b0;
      clkmd_q  <= 1'b0;
    end else begin
      pwrdn_q  <= ctrl_q[CTRL_PWRDN];
      openi_q  <= ctrl_q[CTRL_OPENI];
      openq_q  <= ctrl_q[CTRL_OPENQ];
      format_q <= ctrl_q[CTRL_FORMAT];
      pinmd_q  <= ctrl_q[CTRL_PINMD];
      clkmd_q  <= ctrl_q[CTRL_CLKMD];
    end
  end

  assign plb_dac_0_S_Data_pin   = data_q;
  assign plb_dac_0_S_DCLKIO_pin = dclk_q;
  assign plb_dac_0_S_Clkout_pin = dclk_q;
  assign plb_dac_0_S_PWRDN_pin  = pwrdn_q;
  assign plb_dac_0_S_OpEnI_pin  = openi_q;
  assign plb_dac_0_S_OpEnQ_pin  = openq_q;
  assign plb_dac_0_S_Format_pin = format_q;
  assign plb_dac_0_S_PinMD_pin  = pinmd_q;
  assign plb_dac_0_S_ClkMD_pin  = clkmd_q;

endmodule

// File: tb/tb_microblaze_subsys.sv
// Directed bench: UART commands in, decoded TX bytes checked against an expected-byte queue.
// Runs with a 16-cycle bit period so frames and the inter-byte timeout stay short.
module tb_microblaze_subsys;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tx;
  logic [0:9] data;
  logic       dclk, clkout, pinmd, clkmd, format, pwrdn, openi, openq;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  microblaze_subsys #(.CLK_HZ(1600), .BAUD(100), .TMO_BITS(256)) dut (
    .fpga_0_clk_1_sys_clk_pin (clk),
    .fpga_0_rst_1_sys_rst_pin (rst),
    .fpga_0_RS232_RX_pin      (rx),
    .fpga_0_RS232_TX_pin      (tx),
    .plb_dac_0_S_Data_pin     (data),
    .plb_dac_0_S_DCLKIO_pin   (dclk),
    .plb_dac_0_S_Clkout_pin   (clkout),
    .plb_dac_0_S_PinMD_pin    (pinmd),
    .plb_dac_0_S_ClkMD_pin    (clkmd),
    .plb_dac_0_S_Format_pin   (format),
    .plb_dac_0_S_PWRDN_pin    (pwrdn),
    .plb_dac_0_S_OpEnI_pin    (openi),
    .plb_dac_0_S_OpEnQ_pin    (openq)
  );

  // TX line decoder: each complete frame lands in got_q.
  initial begin
    logic [7:0] b;
    @(negedge rst);
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(negedge clk);
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        got_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic drain(input string tag);
    int t;
    logic [7:0] e, g;
    while (exp_q.size() != 0) begin
      t = 0;
      while (got_q.size() == 0 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      e = exp_q.pop_front();
      vectors++;
      assert (got_q.size() != 0) else begin
        miscompares++;
        $error("FAIL %s: no TX byte observed, expected %h", tag, e);
      end
      if (got_q.size() != 0) begin
        g = got_q.pop_front();
        check(tag, {8'h00, g}, {8'h00, e});
      end
    end
    repeat (BIT * 12) @(negedge clk);
    check({tag, "_extra"}, 16'(got_q.size()), 16'd0);
  endtask

  task automatic wait_dclk(input logic lvl, output int n);
    n = 0;
    while (dclk !== lvl && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_dac(input string tag, input logic [9:0] q_exp, input logic [9:0] i_exp);
    int n0, n1, n2;
    wait_dclk(1'b0, n0);
    wait_dclk(1'b1, n0);
    check({tag, "_q"}, 16'(data), 16'(q_exp));
    check({tag, "_clkout"}, 16'(clkout), 16'd1);
    wait_dclk(1'b0, n1);
    check({tag, "_i"}, 16'(data), 16'(i_exp));
    wait_dclk(1'b1, n2);
    check({tag, "_period"}, 16'(n1 + n2), 16'd4);
    check({tag, "_q2"}, 16'(data), 16'(q_exp));
  endtask

  initial begin
    logic [9:0] held;
    repeat (4) @(negedge clk);
    check("rst_tx", 16'(tx), 16'd1);
    check("rst_data", 16'(data), 16'd0);
    check("rst_dclk", 16'({dclk, clkout}), 16'd0);
    check("rst_pwrdn", 16'(pwrdn), 16'd1);
    check("rst_modes", 16'({openi, openq, format, pinmd, clkmd}), 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_tx", 16'(tx), 16'd1);

    send_byte(8'h8F, 1'b1);
    exp_q.push_back(8'hDA); exp_q.push_back(8'hC1);
    drain("read_id");

    send3(8'h01, 8'h02, 8'h55);
    exp_q.push_back(8'h06);
    send_byte(8'h81, 1'b1);
    exp_q.push_back(8'h02); exp_q.push_back(8'h55);
    drain("wr_rd_i");

    send3(8'h00, 8'h00, 8'h46); exp_q.push_back(8'h06);
    send3(8'h03, 8'h00, 8'h01); exp_q.push_back(8'h06);
    send3(8'h01, 8'h03, 8'hFF); exp_q.push_back(8'h06);
    send3(8'h02, 8'h00, 8'h01); exp_q.push_back(8'h06);
    drain("setup_dac");
    check("run_pins", 16'({pwrdn, openi, openq, format}), 16'b0110);
    check_dac("raw", 10'h001, 10'h3FF);

    send3(8'h00, 8'h00, 8'h4E); exp_q.push_back(8'h06);
    drain("ctrl_fmt");
    check("fmt_pin", 16'(format), 16'd1);
    check_dac("fmt", 10'h201, 10'h1FF);

    send_byte(8'h80, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h4E);
    drain("read_ctrl");

    send3(8'h00, 8'h00, 8'h01); exp_q.push_back(8'h06);
    drain("stop_run");
    held = data;
    repeat (20) @(negedge clk);
    check("stop_dclk", 16'(dclk), 16'd0);
    check("stop_hold", 16'(data), 16'(held));
    check("stop_pins", 16'({pwrdn, openi, openq, format}), 16'b1000);

    send3(8'h07, 8'h12, 8'h34); exp_q.push_back(8'h15);
    drain("bad_addr");
    send3(8'h0F, 8'h00, 8'h00); exp_q.push_back(8'h15);
    drain("ro_write");
    send_byte(8'h17, 1'b1); exp_q.push_back(8'h15);
    drain("bad_cmd");

    send_byte(8'h01, 1'b1);
    send_byte(8'h7A, 1'b0);
    send3(8'h01, 8'h01, 8'h23); exp_q.push_back(8'h06);
    send_byte(8'h81, 1'b1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    drain("ferr");

    send_byte(8'h02, 1'b1);
    repeat (257 * BIT + 100) @(negedge clk);
    send_byte(8'h81, 1'b1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    send_byte(8'h82, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    drain("timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
